axi_crossbar_wr_sched: RTL and testbench

Write-path scheduler for the AXI crossbar: arbitrates AW-channel requests from `AXI_REQUEST_NUM` masters onto one slave port with round-robin fairness, holds each grant until its AW handshake completes, and records grant order in an internal order FIFO. The FIFO head drives W-channel routing, so write data beats are steered in the same order the addresses were accepted. It sits between the master-side AW/W muxes and the slave port, replacing a free-running per-cycle arbiter on the write path.

---
 rtl/axi_crossbar_wr_sched.sv | 159 +++++++++++++++
 tb/tb_axi_crossbar_wr_sched.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_crossbar_wr_sched.sv
// axi_crossbar_wr_sched
// Write-path scheduler for the AXI crossbar. Round-robin arbitration of AW
// requests onto one slave port; each grant is held until its AW handshake.
// Accepted grants are queued in an order FIFO whose head steers the W mux, so
// write data follows address acceptance order.
//
// Optional feature: define AXI_WR_SCHED_QOS_EN to add hi_prio_i. Round-robin
// then runs only over high-priority requesters whenever any of them requests.
module axi_crossbar_wr_sched #(
  parameter int AXI_REQUEST_NUM = 4,
  parameter int ORDER_DEPTH     = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [AXI_REQUEST_NUM-1:0]         aw_req_i,
  input  logic                               aw_ready_i,
`ifdef AXI_WR_SCHED_QOS_EN
  input  logic [AXI_REQUEST_NUM-1:0]         hi_prio_i,
`endif
  output logic [AXI_REQUEST_NUM-1:0]         aw_grant_o,
  output logic [AXI_REQUEST_NUM-1:0]         w_sel_o,
  input  logic                               w_hs_i,
  input  logic                               w_last_i,
  output logic [$clog2(ORDER_DEPTH+1)-1:0]   outstanding_o
);

  localparam int N     = AXI_REQUEST_NUM;
  localparam int IDX_W = $clog2(N);
  localparam int PTR_W = $clog2(ORDER_DEPTH);
  localparam int CNT_W = $clog2(ORDER_DEPTH + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N-1:0]     fifo_mem_q [ORDER_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic [N-1:0]     cand_req;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             granted_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

`ifdef AXI_WR_SCHED_QOS_EN
  logic [N-1:0] hp_req;
  assign hp_req   = aw_req_i & hi_prio_i;
  assign cand_req = (|hp_req) ? hp_req : aw_req_i;
`else
  assign cand_req = aw_req_i;
`endif

  assign fifo_full   = (count_q == CNT_W'(ORDER_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign granted_req = |(grant_q & aw_req_i);
  assign pop         = w_hs_i & w_last_i & ~fifo_empty;

  // Round-robin search: first candidate at or after rr_ptr_q, wrapping mod N.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(rr_ptr_q) + k;
      if (j >= N) j = j - N;
      if (!win_found && cand_req[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  // Grant FSM next state: issue in IDLE, hold until handshake or request drop.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found && !fifo_full) begin
          grant_d = N'(1) << win_idx;
          gidx_d  = win_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (granted_req && aw_ready_i) begin
          push     = 1'b1;
          rr_ptr_d = (gidx_q == IDX_W'(N - 1)) ? '0 : gidx_q + IDX_W'(1);
          grant_d  = '0;
          state_d  = ST_IDLE;
        end else if (!granted_req) begin
          // Master withdrew AWVALID without a handshake: abandon, keep rr_ptr.
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Grant FSM registers.
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (ARESET) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Order FIFO storage: written on each accepted AW.
  always_ff @(posedge ACLK) begin
    // NOTE: storage is not reset; pointers and count define validity and w_sel_o is gated when empty.
    if (push) fifo_mem_q[wr_ptr_q] <= grant_q;
  end

  // Order FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign aw_grant_o    = grant_q;
  assign w_sel_o       = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
  assign outstanding_o = count_q;

endmodule

// File: tb/tb_axi_crossbar_wr_sched.sv
// Bench for axi_crossbar_wr_sched: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_axi_crossbar_wr_sched;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          areset;
  logic [N-1:0]  aw_req;
  logic          aw_ready;
  logic [N-1:0]  hi_prio;
  logic [N-1:0]  aw_grant;
  logic [N-1:0]  w_sel;
  logic          w_hs;
  logic          w_last;
  logic [CW-1:0] outstanding;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: granted master index (-1 = none), rr pointer, order queue.
  int m_granted;
  int m_rr;
  int m_order[$];

  axi_crossbar_wr_sched #(
    .AXI_REQUEST_NUM(N),
    .ORDER_DEPTH    (DEPTH)
  ) dut (
    .ACLK         (clk),
    .ARESET       (areset),
    .aw_req_i     (aw_req),
    .aw_ready_i   (aw_ready),
`ifdef AXI_WR_SCHED_QOS_EN
    .hi_prio_i    (hi_prio),
`endif
    .aw_grant_o   (aw_grant),
    .w_sel_o      (w_sel),
    .w_hs_i       (w_hs),
    .w_last_i     (w_last),
    .outstanding_o(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    int     sz;
    bit     do_pop;
    logic [N-1:0] cand;
    if (areset) begin
      m_granted = -1;
      m_rr      = 0;
      m_order.delete();
      return;
    end
    sz     = m_order.size();
    do_pop = w_hs && w_last && (sz > 0);
    if (m_granted >= 0) begin
      if (aw_req[m_granted] && aw_ready) begin
        m_order.push_back(m_granted);
        m_rr      = (m_granted + 1) % N;
        m_granted = -1;
      end else if (!aw_req[m_granted]) begin
        m_granted = -1;
      end
    end else if (aw_req != '0 && sz < DEPTH) begin
      cand = aw_req;
`ifdef AXI_WR_SCHED_QOS_EN
      if ((aw_req & hi_prio) != '0) cand = aw_req & hi_prio;
`endif
      for (int k = 0; k < N; k++) begin
        if (m_granted < 0 && cand[(m_rr + k) % N]) m_granted = (m_rr + k) % N;
      end
    end
    if (do_pop) void'(m_order.pop_front());
  endtask

  task automatic compare_model();
    logic [31:0] e_grant;
    logic [31:0] e_sel;
    e_grant = (m_granted >= 0) ? (32'd1 << m_granted) : 32'd0;
    e_sel   = (m_order.size() > 0) ? (32'd1 << m_order[0]) : 32'd0;
    check("model_grant", 32'(aw_grant), e_grant);
    check("model_wsel", 32'(w_sel), e_sel);
    check("model_outstanding", 32'(outstanding), 32'(m_order.size()));
  endtask

  // Apply inputs, take one rising edge, then compare away from the edge.
  task automatic step(input logic rst, input logic [N-1:0] req, input logic rdy,
                      input logic hs, input logic last, input logic [N-1:0] hp);
    areset   = rst;
    aw_req   = req;
    aw_ready = rdy;
    w_hs     = hs;
    w_last   = last;
    hi_prio  = hp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    step(1'b1, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    m_granted = -1;
    m_rr      = 0;

    // Reset state.
    do_reset();
    check("rst_grant", 32'(aw_grant), 32'd0);
    check("rst_wsel", 32'(w_sel), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);

    // All masters requesting, slave always ready: rotating grants until full.
    for (int k = 0; k < N; k++) begin
      step(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, '0);
      check("rr_grant", 32'(aw_grant), 32'd1 << k);
      step(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, '0);
      check("rr_outstanding", 32'(outstanding), 32'(k + 1));
    end
    step(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, '0);
    check("full_no_grant", 32'(aw_grant), 32'd0);
    check("full_outstanding", 32'(outstanding), 32'd4);
    check("full_wsel", 32'(w_sel), 32'b0001);

    // One last beat pops the head; a new grant follows next cycle.
    step(1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, '0);
    check("pop_wsel", 32'(w_sel), 32'b0010);
    check("pop_outstanding", 32'(outstanding), 32'd3);
    step(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, '0);
    check("after_pop_grant", 32'(aw_grant), 32'b0001);

    // Grant held while slave not ready, then one push.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, '0);
      check("hold_grant", 32'(aw_grant), 32'b0100);
    end
    check("hold_no_push", 32'(outstanding), 32'd0);
    step(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, '0);
    check("hold_push", 32'(outstanding), 32'd1);
    check("hold_clear", 32'(aw_grant), 32'd0);

    // One entry queued; push and pop on the same edge.
    step(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, '0);
    check("pp_grant", 32'(aw_grant), 32'b0001);
    step(1'b0, 4'b0001, 1'b1, 1'b1, 1'b1, '0);
    check("pp_outstanding", 32'(outstanding), 32'd1);
    check("pp_wsel", 32'(w_sel), 32'b0001);

    // Reset mid-burst with three entries and a held grant.
    do_reset();
    for (int k = 0; k < 6; k++) step(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, '0);
    check("pre_rst_outstanding", 32'(outstanding), 32'd3);
    check("pre_rst_grant", 32'(aw_grant), 32'b1000);
    do_reset();
    check("mid_rst_grant", 32'(aw_grant), 32'd0);
    check("mid_rst_wsel", 32'(w_sel), 32'd0);
    check("mid_rst_outstanding", 32'(outstanding), 32'd0);
    step(1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, '0);
    check("post_rst_grant", 32'(aw_grant), 32'b0001);

`ifdef AXI_WR_SCHED_QOS_EN
    // High-priority subset wins first, then plain round-robin.
    do_reset();
    step(1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 4'b1000);
    check("qos_hi_grant", 32'(aw_grant), 32'b1000);
    step(1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 4'b1000);
    step(1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 4'b0000);
    check("qos_rr0", 32'(aw_grant), 32'b0001);
    step(1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 4'b0000);
    check("qos_rr1", 32'(aw_grant), 32'b0010);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] r_req;
      logic [N-1:0] r_hp;
      logic         r_hs;
      for (int b = 0; b < N; b++) r_req[b] = ($urandom_range(3, 0) != 0);
      r_hp = N'($urandom);
      r_hs = ($urandom_range(9, 0) < 4);
      step(($urandom_range(199, 0) == 0), r_req, ($urandom_range(9, 0) < 7),
           r_hs, ($urandom_range(1, 0) == 1), r_hp);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
